// File: rtl/decode_stage_if.sv
// decode_stage_if: handshake and decoded-bundle signals of the decode stage.
//   slave  : decode stage view (accepts raw words, presents decoded bundle)
//   master : surrounding logic view (offers words, consumes bundle, flushes)
// Signals:
//   in_valid/in_instr/in_ready   raw instruction handshake
//   flush                        discard all buffered instructions
//   out_valid/out_ready          decoded bundle handshake
//   opcode rd rs1 rs2 imm jmp_target + control flags, decode_count
interface decode_stage_if #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned REG_W   = 3,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned COUNT_W = 16
);
  localparam int unsigned TGT_W = INSTR_W - 4;

  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;
  logic               flush;

  logic               out_valid;
  logic               out_ready;
  logic [3:0]         opcode;
  logic [REG_W-1:0]   rd;
  logic [REG_W-1:0]   rs1;
  logic [REG_W-1:0]   rs2;
  logic [DATA_W-1:0]  imm;
  logic [TGT_W-1:0]   jmp_target;
  logic               reg_write;
  logic               uses_imm;
  logic               mem_read;
  logic               mem_write;
  logic               is_branch;
  logic               is_jump;
  logic               link;
  logic [COUNT_W-1:0] decode_count;

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, opcode, rd, rs1, rs2, imm, jmp_target,
           reg_write, uses_imm, mem_read, mem_write, is_branch, is_jump,
           link, decode_count
  );

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, opcode, rd, rs1, rs2, imm, jmp_target,
           reg_write, uses_imm, mem_read, mem_write, is_branch, is_jump,
           link, decode_count
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode with a two-entry skid buffer.
// Splits each raw word into opcode / rd / rs1 / rs2 / sign-extended immediate /
// jump target, derives control flags, buffers up to two decoded bundles and
// counts output handshakes.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    decode_stage_if.slave (input handshake, flush, decoded outputs)
module decode_stage #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned REG_W   = 3,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned COUNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus
);

  localparam int unsigned IMM_W = INSTR_W - 4 - 2 * REG_W;
  localparam int unsigned TGT_W = INSTR_W - 4;
  localparam int unsigned RD_HI  = INSTR_W - 5;
  localparam int unsigned RS1_HI = INSTR_W - 5 - REG_W;
  localparam int unsigned RS2_HI = INSTR_W - 5 - 2 * REG_W;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [DATA_W-1:0] imm;
    logic [TGT_W-1:0]  tgt;
    logic              reg_write;
    logic              uses_imm;
    logic              mem_read;
    logic              mem_write;
    logic              is_branch;
    logic              is_jump;
    logic              link;
  } bundle_t;

  // Bit 0 = OUT valid, bit 1 = SKID valid, so both handshake outputs come
  // straight off state flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t             state_q;
  state_t             state_d;
  bundle_t            dec_c;
  bundle_t            out_q;
  bundle_t            skid_q;
  logic [COUNT_W-1:0] count_q;
  logic               accept_c;
  logic               drain_c;
  logic               load_out_c;
  logic               load_skid_c;
  logic               skid_to_out_c;

  assign accept_c = bus.in_valid & ~state_q[1];
  assign drain_c  = state_q[0] & bus.out_ready;

  // Field extraction and opcode-to-flag map for the incoming word.
  always_comb begin
    dec_c        = '0;
    dec_c.opcode = bus.in_instr[INSTR_W-1 -: 4];
    dec_c.rd     = bus.in_instr[RD_HI  -: REG_W];
    dec_c.rs1    = bus.in_instr[RS1_HI -: REG_W];
    dec_c.rs2    = bus.in_instr[RS2_HI -: REG_W];
    dec_c.imm    = DATA_W'($signed(bus.in_instr[IMM_W-1:0]));
    dec_c.tgt    = bus.in_instr[TGT_W-1:0];
    case (dec_c.opcode)
      4'h0: begin dec_c.reg_write = 1'b1; dec_c.uses_imm = 1'b1; end  // addi
      4'h1: begin dec_c.reg_write = 1'b1; end                         // add
      4'h2: begin                                                     // lb
        dec_c.reg_write = 1'b1;
        dec_c.uses_imm  = 1'b1;
        dec_c.mem_read  = 1'b1;
      end
      4'h3: begin dec_c.reg_write = 1'b1; dec_c.uses_imm = 1'b1; end  // subi
      4'h4: begin dec_c.reg_write = 1'b1; end                         // sub
      4'h5: begin dec_c.is_branch = 1'b1; end                         // beq
      4'h6: begin dec_c.is_branch = 1'b1; end                         // bne
      4'h7: begin dec_c.reg_write = 1'b1; end                         // slt
      4'h8: begin dec_c.reg_write = 1'b1; dec_c.uses_imm = 1'b1; end  // slti
      4'h9: begin dec_c.is_jump = 1'b1; end                           // jump
      4'hA: begin dec_c.uses_imm = 1'b1; dec_c.mem_write = 1'b1; end  // sb
      4'hB: begin dec_c.reg_write = 1'b1; dec_c.uses_imm = 1'b1; end  // sra
      4'hC: begin dec_c.reg_write = 1'b1; dec_c.uses_imm = 1'b1; end  // sll
      4'hD: begin                                                     // jal
        dec_c.reg_write = 1'b1;
        dec_c.is_jump   = 1'b1;
        dec_c.link      = 1'b1;
      end
      4'hE: begin dec_c.reg_write = 1'b1; end                         // nand
      4'hF: begin dec_c.is_branch = 1'b1; end                         // blt
    endcase
  end

  // Buffer occupancy next-state; flush overrides every other event.
  always_comb begin
    state_d       = state_q;
    load_out_c    = 1'b0;
    load_skid_c   = 1'b0;
    skid_to_out_c = 1'b0;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_c) begin
            state_d    = ONE;
            load_out_c = 1'b1;
          end
        end
        ONE: begin
          if (accept_c && drain_c) begin
            load_out_c = 1'b1;
          end else if (accept_c) begin
            state_d     = FULL;
            load_skid_c = 1'b1;
          end else if (drain_c) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain_c) begin
            state_d       = ONE;
            skid_to_out_c = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // OUT and SKID payload registers; data holds while not loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out_c) begin
        out_q <= dec_c;
      end else if (skid_to_out_c) begin
        out_q <= skid_q;
      end
      if (load_skid_c) begin
        skid_q <= dec_c;
      end
    end
  end

  // Output handshake counter; a drain coinciding with flush still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (drain_c) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign bus.in_ready     = ~state_q[1];
  assign bus.out_valid    = state_q[0];
  assign bus.opcode       = out_q.opcode;
  assign bus.rd           = out_q.rd;
  assign bus.rs1          = out_q.rs1;
  assign bus.rs2          = out_q.rs2;
  assign bus.imm          = out_q.imm;
  assign bus.jmp_target   = out_q.tgt;
  assign bus.reg_write    = out_q.reg_write;
  assign bus.uses_imm     = out_q.uses_imm;
  assign bus.mem_read     = out_q.mem_read;
  assign bus.mem_write    = out_q.mem_write;
  assign bus.is_branch    = out_q.is_branch;
  assign bus.is_jump      = out_q.is_jump;
  assign bus.link         = out_q.link;
  assign bus.decode_count = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage. Two instances share the
// stimulus: one with the default 16-bit counter, one with a 4-bit counter.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  decode_stage_if #(.INSTR_W(16), .REG_W(3), .DATA_W(8), .COUNT_W(16)) bus ();
  decode_stage_if #(.INSTR_W(16), .REG_W(3), .DATA_W(8), .COUNT_W(4))  bus4 ();

  decode_stage #(.INSTR_W(16), .REG_W(3), .DATA_W(8), .COUNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  decode_stage #(.INSTR_W(16), .REG_W(3), .DATA_W(8), .COUNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_instr  = bus.in_instr;
  assign bus4.flush     = bus.flush;
  assign bus4.out_ready = bus.out_ready;

  always #5 clk = ~clk;

  // Opcode-indexed flag masks (bit n = opcode n).
  localparam logic [15:0] RW_MASK = 16'h799F;
  localparam logic [15:0] UI_MASK = 16'h1D0D;
  localparam logic [15:0] MR_MASK = 16'h0004;
  localparam logic [15:0] MW_MASK = 16'h0400;
  localparam logic [15:0] BR_MASK = 16'h8060;
  localparam logic [15:0] JP_MASK = 16'h2200;
  localparam logic [15:0] LK_MASK = 16'h2000;

  logic [63:0] sbq[$];
  int          occ;
  int unsigned cnt;
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(input logic [15:0] w);
    logic [3:0]  op;
    logic [15:0] m;
    logic [6:0]  f;
    op = w[15:12];
    m = RW_MASK; f[6] = m[op];
    m = UI_MASK; f[5] = m[op];
    m = MR_MASK; f[4] = m[op];
    m = MW_MASK; f[3] = m[op];
    m = BR_MASK; f[2] = m[op];
    m = JP_MASK; f[1] = m[op];
    m = LK_MASK; f[0] = m[op];
    return {24'd0, op, w[11:9], w[8:6], w[5:3], {{2{w[5]}}, w[5:0]}, w[11:0], f};
  endfunction

  function automatic logic [63:0] bundle16();
    return {24'd0, bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.imm, bus.jmp_target,
            bus.reg_write, bus.uses_imm, bus.mem_read, bus.mem_write,
            bus.is_branch, bus.is_jump, bus.link};
  endfunction

  function automatic logic [63:0] bundle4();
    return {24'd0, bus4.opcode, bus4.rd, bus4.rs1, bus4.rs2, bus4.imm, bus4.jmp_target,
            bus4.reg_write, bus4.uses_imm, bus4.mem_read, bus4.mem_write,
            bus4.is_branch, bus4.is_jump, bus4.link};
  endfunction

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_instr  = 16'h0000;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_count16", 64'(bus.decode_count), 64'(0));
    check("rst_count4", 64'(bus4.decode_count), 64'(0));
    check("rst_bundle16", bundle16(), 64'(0));
    check("rst_bundle4", bundle4(), 64'(0));
  endtask

  // Check what the last edge produced, then drive one cycle and advance the model.
  task automatic step(input bit v, input logic [15:0] w, input bit ordy, input bit fl);
    bit acc;
    bit drn;
    @(negedge clk);
    check("in_ready", 64'(bus.in_ready), 64'(occ < 2));
    check("out_valid", 64'(bus.out_valid), 64'(occ > 0));
    check("in_ready4", 64'(bus4.in_ready), 64'(occ < 2));
    check("out_valid4", 64'(bus4.out_valid), 64'(occ > 0));
    check("count16", 64'(bus.decode_count), 64'(cnt % 65536));
    check("count4", 64'(bus4.decode_count), 64'(cnt % 16));
    if (occ > 0) begin
      check("bundle16", bundle16(), sbq[0]);
      check("bundle4", bundle4(), sbq[0]);
    end
    bus.in_valid  = v;
    bus.in_instr  = w;
    bus.out_ready = ordy;
    bus.flush     = fl;
    acc = v && (occ < 2);
    drn = (occ > 0) && ordy;
    if (drn) begin
      cnt++;
      void'(sbq.pop_front());
    end
    if (fl) begin
      sbq.delete();
    end else if (acc) begin
      sbq.push_back(model(w));
    end
    occ = sbq.size();
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    drive_idle();
    #1;
    check_reset_values();
    sbq.delete();
    occ = 0;
    cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    occ      = 0;
    cnt      = 0;
    drive_idle();
    #1;
    check_reset_values();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single addi, then add/jal back to back.
    step(1'b1, 16'h0A7E, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 16'h1650, 1'b1, 1'b0);
    step(1'b1, 16'hDE05, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Backpressure: fill, stall a third word, then release.
    step(1'b1, 16'h2123, 1'b0, 1'b0);
    step(1'b1, 16'h3456, 1'b0, 1'b0);
    step(1'b1, 16'h4789, 1'b0, 1'b0);
    step(1'b1, 16'h4789, 1'b0, 1'b0);
    step(1'b1, 16'h4789, 1'b1, 1'b0);
    step(1'b1, 16'h4789, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Flush in FULL with a word offered and no drain.
    step(1'b1, 16'h5AAA, 1'b0, 1'b0);
    step(1'b1, 16'h6BBB, 1'b0, 1'b0);
    step(1'b1, 16'h7CCC, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Flush coinciding with a drain: the presented bundle is counted.
    step(1'b1, 16'h8111, 1'b0, 1'b0);
    step(1'b1, 16'h9222, 1'b0, 1'b0);
    step(1'b1, 16'hA333, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Flush from ONE with accept and drain in the same cycle.
    step(1'b1, 16'hF0F0, 1'b1, 1'b0);
    step(1'b1, 16'h0F0F, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Asynchronous reset while FULL, then restart.
    step(1'b1, 16'hB444, 1'b0, 1'b0);
    step(1'b1, 16'hC555, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    async_reset();
    step(1'b1, 16'hE666, 1'b1, 1'b0);

    // Opcode sweep streamed at full rate; 17th handshake wraps the 4-bit counter.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, {4'(i), 12'($urandom)}, 1'b1, 1'b0);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0, ($urandom % 25) == 0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    step(1'b0, 16'h0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered instruction-decode stage between the fetch/ROM assembly logic and the FSM, ALU and register file. It accepts raw instruction words over a valid/ready handshake and splits each word into opcode, register indices, a sign-extended immediate and a jump target. It also derives per-opcode control flags and carries them through a two-entry skid buffer with synchronous flush, plus a decoded-instruction counter.

## Interface
- `INSTR_W`, 16: instruction width; must be ≥ 4 + 3·`REG_W`.
- `REG_W`, 3: register-index width.
- `DATA_W`, 8: datapath width; the immediate is sign-extended to this width.
- `COUNT_W`, 16: width of the decoded-instruction counter.
- Derived: `IMM_W` = `INSTR_W` − 4 − 2·`REG_W` (default 6); `TGT_W` = `INSTR_W` − 4 (default 12).

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `in_valid`  in  1  — instruction word offered.
- `in_instr`  in  `INSTR_W`  — raw instruction.
- `in_ready`  out  1  — stage can accept a word.
- `flush`  in  1  — discard all buffered instructions (taken branch/jump).
- `out_valid`  out  1  — decoded bundle valid.
- `out_ready`  in  1  — consumer accepts the bundle.
- `opcode`  out  4  — `instr[INSTR_W-1 -: 4]`.
- `rd`, `rs1`, `rs2`  out  `REG_W` each — next three fields below the opcode, MSB-first.
- `imm`  out  `DATA_W`  — `instr[IMM_W-1:0]` sign-extended.
- `jmp_target`  out  `TGT_W`  — `instr[TGT_W-1:0]` zero-extended.
- `reg_write`, `uses_imm`, `mem_read`, `mem_write`, `is_branch`, `is_jump`, `link`  out  1 each — control flags.
- `decode_count`  out  `COUNT_W`  — number of output handshakes, modulo 2^`COUNT_W`.

## Operation
- Opcode map: 0 addi, 1 add, 2 lb, 3 subi, 4 sub, 5 beq, 6 bne, 7 slt, 8 slti, 9 jump, A sb, B sra, C sll, D jal, E nand, F blt. All 16 codes are legal.
- `reg_write` = 1 for addi, add, lb, subi, sub, slt, slti, sra, sll, jal, nand.
- `uses_imm` = 1 for addi, lb, subi, slti, sb, sra, sll.
- `mem_read` = 1 for lb only. `mem_write` = 1 for sb only.
- `is_branch` = 1 for beq, bne, blt. `is_jump` = 1 for jump, jal. `link` = 1 for jal only.
- Decode is combinational on the incoming word. The result is captured into the output register (OUT) or the skid register (SKID).
- Buffer states:
  - EMPTY: OUT invalid.
  - ONE: OUT valid, SKID empty.
  - FULL: both valid.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept with no drain → FULL (word goes to SKID).
  - ONE + drain with no accept → EMPTY.
  - ONE + accept and drain → ONE (new word into OUT).
  - FULL + drain → ONE (SKID moves to OUT).
- Accept = `in_valid` & `in_ready`. Drain = `out_valid` & `out_ready`.
- `in_ready` = !SKID-valid, taken from a register, so there is no combinational path from `out_ready`.
- `in_ready` = 0 only in FULL. FULL with no accept and no drain holds all state.
- Flush wins over every other event. On the edge with `flush`=1, both entries are invalidated (→ EMPTY) and any word accepted that cycle is dropped.
- `decode_count` increments on every drain, including a drain in the same cycle as `flush`. It wraps at 2^`COUNT_W`.
- Output data fields hold their last value while `out_valid`=0; consumers must ignore them.

## Timing
- Reset values while `rst_n` is low: `out_valid`=0, `in_ready`=1, all data and flag outputs 0, `decode_count`=0. Reset applies immediately, without waiting for a clock edge.
- Deassertion of `rst_n` is synchronised externally. The first accept can occur on the first edge after release.
- Latency: a word accepted at edge N appears with `out_valid`=1 after edge N.
- Throughput: one instruction per cycle while `out_ready`=1.
- Reset asserted mid-stream discards both entries. No partial bundle is ever presented.
- `flush` together with `out_ready`=1: the bundle currently presented is counted as consumed. Its successors are discarded.

## Test plan
- Reset, then `in_instr`=0x0A7E (addi) → next cycle: `opcode`=0, `rd`=5, `rs1`=1, `rs2`=7, `imm`=0xFE, `reg_write`=1, `uses_imm`=1, all other flags 0.
- 0x1650 (add), then 0xDE05 (jal), back-to-back with `out_ready`=1 → add: `rd`=3, `rs1`=1, `rs2`=2, `uses_imm`=0. jal: `jmp_target`=0xE05, `is_jump`=1, `link`=1, `reg_write`=1, `rd`=7. `decode_count`=2.
- Hold `out_ready`=0 and offer 3 words → first two accepted, `in_ready`=0 after the second. Release `out_ready` → words emerge in order, the third is accepted, and nothing is lost or duplicated.
- In FULL, assert `flush` with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, offered word dropped, `decode_count` unchanged.
- Pull `rst_n` low while FULL with `decode_count`=5 → outputs reach their reset values without a clock edge. After release, the stream restarts from an empty buffer.
- Set `COUNT_W`=4 and stream 17 instructions → `decode_count`=1. Sweep all 16 opcodes and check every flag against the map.
